// File: rtl/spi_post_arbiter.sv
// spi_post_arbiter
//
// Round-robin arbiter that shares one SPI controller among four requesters.
// A transaction runs through these states:
//   1. A request is granted.
//   2. GO is raised toward the controller.
//   3. The arbiter waits for the synchronized BUSY to rise, then to fall.
//   4. The received word is returned with a one-cycle DONE pulse to the
//      granted requester.
//   5. GO is held low for GAP_CYC cycles so the controller's divided clock
//      domain sees it drop before the next transaction starts.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a 24-bit watchdog counts the cycles spent in LAUNCH and XFER.
//   After TIMEOUT_CYC cycles it forces completion with ERR=1.
//   When undefined, ERR is tied low and the arbiter waits indefinitely.
//
// Ports:
//   CLK       system clock
//   RST       asynchronous active-high reset
//   REQ[3:0]  request, one bit per requester
//   TX_BUS    requester i's TX word at [16i+15:16i]
//   GNT[3:0]  one-hot grant, held through the transaction
//   DONE[3:0] one-cycle completion pulse to the granted requester
//   RX_DATA   received word, held until the next normal completion
//   ERR       valid with DONE, 1 = watchdog timeout
//   ARB_BUSY  high in every state except IDLE
//   SPI_GO    GO to the controller
//   SPI_TX    TX word to the controller
//   SPI_RX    RX word from the controller
//   SPI_BUSY  BUSY from the controller (asynchronous to CLK)

module spi_post_arbiter #(
    parameter logic [15:0] GAP_CYC     = 16'd64,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [63:0] TX_BUS,
    output logic [3:0]  GNT,
    output logic [3:0]  DONE,
    output logic [15:0] RX_DATA,
    output logic        ERR,
    output logic        ARB_BUSY,
    output logic        SPI_GO,
    output logic [15:0] SPI_TX,
    input  logic [15:0] SPI_RX,
    input  logic        SPI_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_XFER,
        S_DONE,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        busy_meta;
    logic        busy_s;
    logic [1:0]  last_grant;
    logic [1:0]  gnt_idx;
    logic [1:0]  grant_idx;
    logic        grant_found;
    logic [15:0] gap_cnt;
    logic        gap_last;
    logic        complete_ok;
    logic        complete_to;
    logic        timeout_hit;

    // Two-flop synchronizer for the controller's BUSY
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= SPI_BUSY;
            busy_s    <= busy_meta;
        end
    end

    // Round-robin search. Walking the offsets from farthest to nearest lets
    // the nearest set bit after last_grant overwrite the others.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant + 2'd1;
        for (int i = 3; i >= 0; i--) begin
            if (REQ[last_grant + 2'(i) + 2'd1]) begin
                grant_found = 1'b1;
                grant_idx   = last_grant + 2'(i) + 2'd1;
            end
        end
    end

    // Widened compare so GAP_CYC=0 still yields a single GAP cycle
    assign gap_last = (({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYC});

`ifdef SPI_ARB_TIMEOUT_EN
    logic [23:0] wd_cnt;
    logic        err_r;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt <= 24'd0;
        end else if (state == S_IDLE) begin
            wd_cnt <= 24'd0;
        end else if (state == S_LAUNCH || state == S_XFER) begin
            wd_cnt <= wd_cnt + 24'd1;
        end
    end

    // Fires in the last allowed cycle so DONE lands TIMEOUT_CYC cycles after LAUNCH entry
    assign timeout_hit = (state == S_LAUNCH || state == S_XFER) &&
                         (({1'b0, wd_cnt} + 25'd1) >= {1'b0, TIMEOUT_CYC});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_r <= 1'b0;
        end else if (complete_ok) begin
            err_r <= 1'b0;
        end else if (complete_to) begin
            err_r <= 1'b1;
        end
    end

    assign ERR = err_r;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
    assign ERR            = 1'b0;
`endif

    // A normal end in XFER takes precedence over a coincident timeout because its data is valid
    assign complete_ok = (state == S_XFER) && !busy_s;
    assign complete_to = timeout_hit && !complete_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (complete_to) begin
                    state_next = S_DONE;
                end else if (busy_s) begin
                    state_next = S_XFER;
                end
            end
            S_XFER: begin
                if (complete_ok || complete_to) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_GAP;
            end
            S_GAP: begin
                if (gap_last) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // DONE and RX_DATA are registered on the completing edge so they appear together with the DONE state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT        <= 4'd0;
            DONE       <= 4'd0;
            RX_DATA    <= 16'd0;
            SPI_TX     <= 16'd0;
            last_grant <= 2'd3;
            gnt_idx    <= 2'd0;
            gap_cnt    <= 16'd0;
        end else begin
            DONE <= 4'd0;

            if (state == S_IDLE && grant_found) begin
                GNT     <= 4'b0001 << grant_idx;
                gnt_idx <= grant_idx;
                SPI_TX  <= TX_BUS[{grant_idx, 4'd0} +: 16];
            end

            if (complete_ok) begin
                DONE    <= GNT;
                RX_DATA <= SPI_RX;
            end else if (complete_to) begin
                DONE <= GNT;
            end

            if (state == S_DONE) begin
                last_grant <= gnt_idx;
                GNT        <= 4'd0;
            end

            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
            end else begin
                gap_cnt <= 16'd0;
            end
        end
    end

    assign SPI_GO   = (state == S_LAUNCH);
    assign ARB_BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_spi_post_arbiter.sv
// tb_spi_post_arbiter
//
// Directed bench for spi_post_arbiter.
// A behavioural controller model answers GO by raising BUSY after a
// programmable delay, loops the TX word back as RX, then drops BUSY.
// The timeout scenario is built only when SPI_ARB_TIMEOUT_EN is defined.

module tb_spi_post_arbiter;

    localparam logic [15:0] GAP = 16'd4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [63:0] TX_BUS;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic [15:0] RX_DATA;
    logic        ERR;
    logic        ARB_BUSY;
    logic        SPI_GO;
    logic [15:0] SPI_TX;
    logic [15:0] SPI_RX;
    logic        SPI_BUSY;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cyc            = 0;

    bit          ctrl_en       = 1'b1;
    int          ctrl_delay    = 0;
    int          ctrl_len      = 8;
    int          xfer_count    = 0;
    int          busy_rise_cyc = 0;
    int          busy_fall_cyc = 0;
    logic [15:0] tx_seen;

    int          done_pulses = 0;
    logic        go_prev     = 1'b0;
    int          go_fall_cyc = 0;
    logic [3:0]  gnt_acc     = 4'd0;

    spi_post_arbiter #(
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .TX_BUS   (TX_BUS),
        .GNT      (GNT),
        .DONE     (DONE),
        .RX_DATA  (RX_DATA),
        .ERR      (ERR),
        .ARB_BUSY (ARB_BUSY),
        .SPI_GO   (SPI_GO),
        .SPI_TX   (SPI_TX),
        .SPI_RX   (SPI_RX),
        .SPI_BUSY (SPI_BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Controller model: one BUSY pulse per GO, aborted by reset
    initial begin
        SPI_BUSY = 1'b0;
        SPI_RX   = 16'd0;
        tx_seen  = 16'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (ctrl_en && SPI_GO && !RST) begin
                for (int d = 0; d < ctrl_delay && !RST; d++) begin
                    @(posedge CLK);
                    #1;
                end
                if (!RST) begin
                    tx_seen       = SPI_TX;
                    SPI_BUSY      = 1'b1;
                    busy_rise_cyc = cyc;
                    xfer_count++;
                    for (int c = 0; c < ctrl_len && !RST; c++) begin
                        @(posedge CLK);
                        #1;
                    end
                    if (!RST) SPI_RX = tx_seen;
                    SPI_BUSY      = 1'b0;
                    busy_fall_cyc = cyc;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (DONE != 4'd0) done_pulses++;
        if (go_prev && !SPI_GO) go_fall_cyc = cyc;
        go_prev = SPI_GO;
        gnt_acc = gnt_acc | GNT;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic [63:0] tx);
        REQ    = req;
        TX_BUS = tx;
    endtask

    task automatic wait_gnt(input string tag, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (GNT != 4'd0) begin
                at_cyc = cyc;
                break;
            end
        end
        check_output(tag, 32'(at_cyc >= 0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (DONE != 4'd0) begin
                at_cyc = cyc;
                break;
            end
        end
        check_output(tag, 32'(at_cyc >= 0), 32'd1);
    endtask

    task automatic wait_xfer(input string tag);
        for (int i = 0; i < 100 && !(SPI_BUSY && !SPI_GO); i++) @(negedge CLK);
        check_output(tag, 32'(SPI_BUSY && !SPI_GO), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_gnt"},  32'(GNT),      32'd0);
        check_output({tag, "_done"}, 32'(DONE),     32'd0);
        check_output({tag, "_rx"},   32'(RX_DATA),  32'd0);
        check_output({tag, "_err"},  32'(ERR),      32'd0);
        check_output({tag, "_busy"}, 32'(ARB_BUSY), 32'd0);
        check_output({tag, "_go"},   32'(SPI_GO),   32'd0);
        check_output({tag, "_tx"},   32'(SPI_TX),   32'd0);
    endtask

    int t;
    int t0;
    int base;
    int pulses_before;
    int go_high;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        RST = 1'b1;
        apply_stimulus(4'd0, 64'd0);
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Single request from requester 2
        $display("[TB] single request");
        base = xfer_count;
        apply_stimulus(4'b0100, {16'h1111, 16'hA55A, 16'h2222, 16'h3333});
        @(negedge CLK);
        check_output("single_gnt",  32'(GNT),      32'h4);
        check_output("single_tx",   32'(SPI_TX),   32'hA55A);
        check_output("single_go",   32'(SPI_GO),   32'd1);
        check_output("single_busy", 32'(ARB_BUSY), 32'd1);
        apply_stimulus(4'd0, 64'd0);
        wait_done("single_done_seen", 200, t);
        check_output("single_done",    32'(DONE),              32'h4);
        check_output("single_rx",      32'(RX_DATA),           32'hA55A);
        check_output("single_err",     32'(ERR),               32'd0);
        check_output("single_latency", 32'(t - busy_fall_cyc), 32'd3);
        @(negedge CLK);
        check_output("single_pulse_end", 32'(DONE),              32'd0);
        check_output("single_xfers",     32'(xfer_count - base), 32'd1);

        // Contention after reset: order 0,1,2,3,0
        $display("[TB] contention");
        RST = 1'b1;
        @(negedge CLK);
        RST  = 1'b0;
        base = xfer_count;
        apply_stimulus(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        for (int k = 0; k < 5; k++) begin
            wait_gnt("rr_gnt_seen", 100, t);
            check_output("rr_gnt", 32'(GNT), 32'd1 << exp_order[k]);
            wait_done("rr_done_seen", 200, t);
            check_output("rr_done", 32'(DONE),    32'd1 << exp_order[k]);
            check_output("rr_rx",   32'(RX_DATA), 32'(exp_order[k] + 1));
        end
        apply_stimulus(4'd0, 64'd0);
        check_output("rr_xfers", 32'(xfer_count - base), 32'd5);

        // Slow controller: GO handshake timing
        $display("[TB] slow controller");
        ctrl_delay = 5;
        ctrl_len   = 20;
        base       = xfer_count;
        apply_stimulus(4'b0010, {16'h0, 16'h0, 16'h5A0F, 16'h0});
        wait_gnt("slow_gnt_seen", 100, t);
        apply_stimulus(4'd0, 64'd0);
        wait_done("slow_done_seen", 400, t);
        check_output("slow_done",    32'(DONE),                        32'h2);
        check_output("slow_rx",      32'(RX_DATA),                     32'h5A0F);
        check_output("slow_go_fall", 32'(go_fall_cyc - busy_rise_cyc), 32'd3);
        check_output("slow_latency", 32'(t - busy_fall_cyc),           32'd3);
        go_high = 0;
        for (int i = 0; i < int'(GAP) + 1; i++) begin
            @(negedge CLK);
            if (SPI_GO) go_high++;
        end
        check_output("slow_go_in_gap", 32'(go_high),           32'd0);
        check_output("slow_xfers",     32'(xfer_count - base), 32'd1);
        ctrl_delay = 0;
        ctrl_len   = 8;

        // Reset while the controller is busy
        $display("[TB] reset mid transfer");
        apply_stimulus(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1234});
        wait_gnt("rst_gnt_seen", 100, t);
        apply_stimulus(4'd0, 64'd0);
        wait_xfer("rst_xfer_reached");
        pulses_before = done_pulses;
        RST = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_output("midrst_no_done", 32'(done_pulses - pulses_before), 32'd0);
        apply_stimulus(4'b1000, {16'hBEEF, 16'h0, 16'h0, 16'h0});
        wait_gnt("post_rst_gnt_seen", 100, t);
        check_output("post_rst_gnt", 32'(GNT), 32'h8);
        apply_stimulus(4'd0, 64'd0);
        wait_done("post_rst_done_seen", 200, t);
        check_output("post_rst_done", 32'(DONE),    32'h8);
        check_output("post_rst_rx",   32'(RX_DATA), 32'hBEEF);

        // Withdrawal: REQ[1] pulsed while requester 0 is in XFER
        $display("[TB] withdrawal");
        apply_stimulus(4'b0001, {16'h0, 16'h0, 16'h7777, 16'hC0DE});
        wait_gnt("wd_gnt_seen", 100, t);
        apply_stimulus(4'd0, {16'h0, 16'h0, 16'h7777, 16'hC0DE});
        wait_xfer("wd_xfer_reached");
        #2 gnt_acc = 4'd0;
        REQ = 4'b0010;
        @(negedge CLK);
        REQ = 4'd0;
        wait_done("wd_done_seen", 200, t);
        check_output("wd_done", 32'(DONE),    32'h1);
        check_output("wd_rx",   32'(RX_DATA), 32'hC0DE);
        repeat (int'(GAP) + 4) @(negedge CLK);
        check_output("wd_no_gnt1", 32'(gnt_acc[1]), 32'd0);
        check_output("wd_idle",    32'(ARB_BUSY),   32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog: controller never answers
        $display("[TB] timeout");
        ctrl_en = 1'b0;
        apply_stimulus(4'b0001, {16'h0, 16'h0, 16'h0, 16'h9999});
        wait_gnt("to_gnt_seen", 100, t0);
        apply_stimulus(4'd0, 64'd0);
        wait_done("to_done_seen", 300, t);
        check_output("to_latency", 32'(t - t0),   32'd100);
        check_output("to_done",    32'(DONE),     32'h1);
        check_output("to_err",     32'(ERR),      32'd1);
        check_output("to_rx",      32'(RX_DATA),  32'hC0DE);
        repeat (int'(GAP) + 4) @(negedge CLK);
        check_output("to_idle",    32'(ARB_BUSY), 32'd0);
        ctrl_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
